uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_fifo.sv | 65 ++++++
 rtl/uart_rx.sv | 175 +++++++++++++++++
 tb/tb_uart_rx.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and bit-timing math.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } uart_state_t;

    // System clocks per line bit (integer division, truncating).
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // Clocks from the start-bit falling edge to the middle of the start bit.
    function automatic int half_bit(input int cpb);
        return cpb / 2;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small receive FIFO: registered storage, extra pointer bit distinguishes full from empty.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem_r [DEPTH];
    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    logic [AW:0] wr_ptr_s;
    logic [AW:0] rd_ptr_s;
    logic        full_r;
    logic        empty_r;
    logic        do_push_s;
    logic        do_pop_s;

    // Accept pop only when data exists; a push into a full FIFO needs a same-cycle pop.
    always_comb begin
        do_pop_s  = pop & ~empty_r;
        do_push_s = push & (~full_r | do_pop_s);
        wr_ptr_s  = wr_ptr_r + {{AW{1'b0}}, do_push_s};
        rd_ptr_s  = rd_ptr_r + {{AW{1'b0}}, do_pop_s};
    end

    // Pointer, flag and storage registers; storage is cleared so the head reads zero after reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else begin
            wr_ptr_r <= wr_ptr_s;
            rd_ptr_r <= rd_ptr_s;
            empty_r  <= (wr_ptr_s == rd_ptr_s);
            full_r   <= (wr_ptr_s[AW] != rd_ptr_s[AW]) &&
                        (wr_ptr_s[AW-1:0] == rd_ptr_s[AW-1:0]);
            if (do_push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= wdata;
            end else begin
                mem_r[wr_ptr_r[AW-1:0]] <= mem_r[wr_ptr_r[AW-1:0]];
            end
        end
    end

    assign rdata = mem_r[rd_ptr_r[AW-1:0]];
    assign full  = full_r;
    assign empty = empty_r;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling FSM, sticky error flags, receive FIFO.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 12000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_pop,
    output logic       frame_err,
    output logic       overrun,
    input  logic       err_clr,
    output logic       busy
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int HALF         = half_bit(CLKS_PER_BIT);
    localparam int CW           = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);

    uart_state_t state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [2:0]    bit_r, bit_s;
    logic [7:0]    shift_r, shift_s;
    logic          sync1_r;
    logic          rxs_r;
    logic          push_s;
    logic          frame_evt_s;
    logic          overrun_evt_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic          frame_err_r;
    logic          overrun_r;
    logic          busy_r;

    // Two-flop synchronizer for the asynchronous line; idles high out of reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1_r <= 1'b1;
            rxs_r   <= 1'b1;
        end else begin
            sync1_r <= rx;
            rxs_r   <= sync1_r;
        end
    end

    // Next-state logic: start qualification at half bit, then one sample per bit period.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r + CW'(1);
        bit_s       = bit_r;
        shift_s     = shift_r;
        push_s      = 1'b0;
        frame_evt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_s = '0;
                if (!rxs_r) begin
                    state_s = ST_START;
                    bit_s   = 3'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_r == HALF_END) begin
                    cnt_s = '0;
                    if (rxs_r) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    state_s = ST_START;
                end
            end
            ST_DATA: begin
                if (cnt_r == BIT_END) begin
                    cnt_s   = '0;
                    shift_s = {rxs_r, shift_r[7:1]};
                    bit_s   = bit_r + 3'd1;
                    if (bit_r == 3'd7) begin
                        state_s = ST_STOP;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (cnt_r == BIT_END) begin
                    cnt_s = '0;
                    if (rxs_r) begin
                        push_s  = 1'b1;
                        state_s = ST_IDLE;
                    end else begin
                        frame_evt_s = 1'b1;
                        state_s     = ST_WAIT_IDLE;
                    end
                end else begin
                    state_s = ST_STOP;
                end
            end
            ST_WAIT_IDLE: begin
                cnt_s = '0;
                if (rxs_r) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    // FSM and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            bit_r   <= 3'd0;
            shift_r <= 8'h00;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            bit_r   <= bit_s;
            shift_r <= shift_s;
            busy_r  <= (state_s != ST_IDLE);
        end
    end

    // A byte is lost only when the FIFO is full and nothing leaves in the same cycle.
    assign overrun_evt_s = push_s & fifo_full_s & ~rx_pop;

    // Sticky error flags; a new event outranks a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            frame_err_r <= (frame_err_r & ~err_clr) | frame_evt_s;
            overrun_r   <= (overrun_r & ~err_clr) | overrun_evt_s;
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push_s),
        .pop    (rx_pop),
        .wdata  (shift_r),
        .rdata  (rx_data),
        .full   (fifo_full_s),
        .empty  (fifo_empty_s)
    );

    assign rx_valid  = ~fifo_empty_s;
    assign frame_err = frame_err_r;
    assign overrun   = overrun_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx against a queue-based model of the receive path.
module tb_uart_rx;

    localparam int CPB   = 12000000 / 115200;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       rx = 1'b1;
    logic       rx_pop = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;
    int idx = 0;
    int pop_at = -1;
    int first_valid = -1;
    int push_idx = -1;
    logic [7:0] exp_q[$];
    logic       exp_ovr = 1'b0;
    logic       exp_ferr = 1'b0;
    logic [7:0] b;

    always #5 clk = ~clk;

    uart_rx dut (
        .clk       (clk),
        .resetn    (resetn),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_pop    (rx_pop),
        .frame_err (frame_err),
        .overrun   (overrun),
        .err_clr   (err_clr),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: a good frame enters the queue unless it is full (then it is dropped).
    task automatic model_frame(input logic [7:0] v, input logic popped_same_cycle);
        if (popped_same_cycle && exp_q.size() > 0) exp_q.pop_front();
        if (exp_q.size() < DEPTH) exp_q.push_back(v);
        else exp_ovr = 1'b1;
    endtask

    task automatic drive_bit(input logic v);
        for (int c = 0; c < CPB; c++) begin
            @(negedge clk);
            if (first_valid < 0 && rx_valid) first_valid = idx;
            rx     = v;
            rx_pop = (idx == pop_at);
            idx++;
        end
    endtask

    task automatic send_frame(input logic [7:0] v, input logic stop);
        idx = 0;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(v[i]);
        drive_bit(stop);
        rx_pop = 1'b0;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic pop_check(input string tag);
        check({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
        if (exp_q.size() > 0) begin
            check({tag, "_data"}, {24'd0, rx_data}, {24'd0, exp_q[0]});
            void'(exp_q.pop_front());
        end
        @(negedge clk); rx_pop = 1'b1;
        @(negedge clk); rx_pop = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        exp_ovr  = 1'b0;
        exp_ferr = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (5) @(negedge clk);
        check("rst_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_data", {24'd0, rx_data}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_ovr", {31'd0, overrun}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        resetn = 1'b1;
        idle(10);

        // Single byte 0xA5; record when rx_valid first rises (must be inside the stop bit)
        first_valid = -1;
        send_frame(8'hA5, 1'b1);
        model_frame(8'hA5, 1'b0);
        idle(3);
        check("a5_in_stop_bit", {31'd0, (first_valid >= 9*CPB && first_valid < 10*CPB)}, 32'd1);
        push_idx = first_valid - 1;
        check("a5_ferr", {31'd0, frame_err}, 32'd0);
        pop_check("a5");
        check("a5_empty_after_pop", {31'd0, rx_valid}, 32'd0);

        // 30-clock glitch on idle line
        @(negedge clk); rx = 1'b0;
        repeat (10) @(negedge clk);
        check("glitch_busy", {31'd0, busy}, 32'd1);
        repeat (20) @(negedge clk);
        idle(200);
        check("glitch_busy_end", {31'd0, busy}, 32'd0);
        check("glitch_valid", {31'd0, rx_valid}, 32'd0);
        check("glitch_ferr", {31'd0, frame_err}, 32'd0);
        check("glitch_ovr", {31'd0, overrun}, 32'd0);

        // Framing error: 0x3C with low stop bit, then line high
        send_frame(8'h3C, 1'b0);
        exp_ferr = 1'b1;
        idle(30);
        check("ferr_set", {31'd0, frame_err}, {31'd0, exp_ferr});
        check("ferr_fifo_empty", {31'd0, rx_valid}, 32'd0);
        check("ferr_busy", {31'd0, busy}, 32'd0);
        pulse_clr();
        @(negedge clk);
        check("ferr_clr", {31'd0, frame_err}, {31'd0, exp_ferr});

        // DEPTH+1 random bytes back-to-back with no pops: last one dropped
        for (int k = 0; k < DEPTH + 1; k++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(b, 1'b1);
            model_frame(b, 1'b0);
        end
        idle(20);
        check("ovr_set", {31'd0, overrun}, {31'd0, exp_ovr});
        for (int k = 0; k < DEPTH; k++) pop_check("ovr_drain");
        check("ovr_drained", {31'd0, rx_valid}, 32'd0);
        pulse_clr();
        @(negedge clk);
        check("ovr_clr", {31'd0, overrun}, 32'd0);

        // Full FIFO, pop lands on the push cycle of the extra byte: no loss
        for (int k = 0; k < DEPTH; k++) begin
            b = 8'($urandom_range(0, 255));
            send_frame(b, 1'b1);
            model_frame(b, 1'b0);
        end
        b = 8'($urandom_range(0, 255));
        pop_at = push_idx;
        send_frame(b, 1'b1);
        pop_at = -1;
        model_frame(b, 1'b1);
        idle(20);
        check("race_ovr", {31'd0, overrun}, {31'd0, exp_ovr});
        for (int k = 0; k < DEPTH; k++) pop_check("race_drain");
        check("race_drained", {31'd0, rx_valid}, 32'd0);

        // Reset during bit 4 of 0xFF, then 0x55 must be the only byte received
        idx = 0;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        repeat (20) @(negedge clk);
        resetn = 1'b0;
        repeat (5) @(negedge clk);
        resetn = 1'b1;
        exp_q.delete();
        exp_ovr = 1'b0;
        exp_ferr = 1'b0;
        idle(1200);
        check("rstmid_valid", {31'd0, rx_valid}, 32'd0);
        check("rstmid_ferr", {31'd0, frame_err}, 32'd0);
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        send_frame(8'h55, 1'b1);
        model_frame(8'h55, 1'b0);
        idle(5);
        pop_check("rstmid_55");
        check("rstmid_only_one", {31'd0, rx_valid}, 32'd0);

        // Random bytes, random gaps, random pops
        for (int k = 0; k < 6; k++) begin
            idle($urandom_range(0, 30));
            b = 8'($urandom_range(0, 255));
            send_frame(b, 1'b1);
            model_frame(b, 1'b0);
            idle(3);
            if ($urandom_range(0, 1) == 1 || exp_q.size() >= DEPTH - 1) pop_check("rand");
        end
        while (exp_q.size() > 0) pop_check("rand_drain");
        check("rand_empty", {31'd0, rx_valid}, 32'd0);
        check("rand_ovr", {31'd0, overrun}, {31'd0, exp_ovr});
        check("rand_ferr", {31'd0, frame_err}, {31'd0, exp_ferr});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
